// File: rtl/axi_req_gen.sv
// axi_req_gen: AXI4 master traffic generator.
// Writes NUM_REQ INCR bursts whose beats carry their own byte address, reads the same
// bursts back and counts every mismatching beat, error response and misplaced rlast.
// Optional stall watchdog is compiled in when AXI_REQ_GEN_TIMEOUT_EN is defined.
module axi_req_gen #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ID_WIDTH    = 4,
  parameter int                    NUM_REQ     = 8,
  parameter int                    BURST_LEN   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic                    req_finish,
  output logic [15:0]             err_cnt,
  output logic                    timeout_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE = 3'($clog2(BYTES));
  localparam int BW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int KW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BURST = BW'(NUM_REQ - 1);
  localparam logic [KW-1:0] LAST_BEAT = KW'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * BYTES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic [BW-1:0]         r_burst;
  logic [KW-1:0]         r_beat;
  logic [15:0]           r_err_cnt;
  logic [ADDR_WIDTH-1:0] w_burst_addr;
  logic [ADDR_WIDTH-1:0] w_beat_addr;
  logic [DATA_WIDTH-1:0] w_exp_data;
  logic w_hs_aw, w_hs_w, w_hs_b, w_hs_ar, w_hs_r;
  logic w_last_beat, w_last_burst, w_burst_done;
  logic w_e_b, w_e_data, w_e_resp, w_e_last, w_e_to, w_timeout;
  logic [2:0]            w_err_inc;
  logic [16:0]           w_err_sum;

  // Burst address and the address-derived beat data (payload only moves on handshakes)
  assign w_burst_addr = BASE_ADDR + ADDR_WIDTH'(r_burst) * BURST_BYTES;
  assign w_beat_addr  = w_burst_addr + (ADDR_WIDTH'(r_beat) << SIZE);
  assign w_exp_data   = DATA_WIDTH'(w_beat_addr);
  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign w_last_burst = (r_burst == LAST_BURST);

  assign m_awid     = '0;
  assign m_awaddr   = w_burst_addr;
  assign m_awlen    = 8'(BURST_LEN - 1);
  assign m_awsize   = SIZE;
  assign m_awburst  = 2'b01;
  assign m_awvalid  = (r_state == S_AW);
  assign m_wdata    = w_exp_data;
  assign m_wstrb    = '1;
  assign m_wlast    = (r_state == S_W) && w_last_beat;
  assign m_wvalid   = (r_state == S_W);
  assign m_bready   = (r_state == S_B);
  assign m_arid     = '0;
  assign m_araddr   = w_burst_addr;
  assign m_arlen    = 8'(BURST_LEN - 1);
  assign m_arsize   = SIZE;
  assign m_arburst  = 2'b01;
  assign m_arvalid  = (r_state == S_AR);
  assign m_rready   = (r_state == S_R);
  assign req_finish = (r_state == S_DONE);
  assign err_cnt    = r_err_cnt;

  assign w_hs_aw = m_awvalid & m_awready;
  assign w_hs_w  = m_wvalid & m_wready;
  assign w_hs_b  = m_bready & m_bvalid;
  assign w_hs_ar = m_arvalid & m_arready;
  assign w_hs_r  = m_rready & m_rvalid;
  assign w_burst_done = w_hs_b | (w_hs_r & w_last_beat);

  // Per-beat error sources; several may hit the same beat and are summed
  assign w_e_b    = w_hs_b & (m_bresp != 2'b00);
  assign w_e_data = w_hs_r & (m_rdata != w_exp_data);
  assign w_e_resp = w_hs_r & (m_rresp != 2'b00);
  assign w_e_last = w_hs_r & (m_rlast != w_last_beat);
  assign w_err_inc = 3'(w_e_b) + 3'(w_e_data) + 3'(w_e_resp) + 3'(w_e_last) + 3'(w_e_to);
  assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_err_inc);

`ifdef AXI_REQ_GEN_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] r_wdog;
  logic           r_timeout_err;
  logic           w_active;
  logic           w_unused;

  assign w_active    = (r_state == S_AW) || (r_state == S_W) || (r_state == S_B) ||
                       (r_state == S_AR) || (r_state == S_R);
  assign w_timeout   = w_active && (r_wdog == WDW'(TIMEOUT_CYC));
  assign w_e_to      = w_timeout;
  assign timeout_err = r_timeout_err;
  assign w_unused    = ^{m_bid, m_rid};

  // Watchdog: restarts on any progress, saturates at the limit, latches the fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((w_state_next != r_state) || w_hs_aw || w_hs_w || w_hs_b || w_hs_ar || w_hs_r)
        r_wdog <= '0;
      else if (r_wdog != WDW'(TIMEOUT_CYC))
        r_wdog <= r_wdog + WDW'(1);
      if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_timeout   = 1'b0;
  assign w_e_to      = 1'b0;
  assign timeout_err = 1'b0;
  assign w_unused    = ^{m_bid, m_rid, (TIMEOUT_CYC > 0)};
`endif

  // Sequencer: write phase (AW/W/B per burst), then read phase (AR/R per burst)
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: w_state_next = S_AW;
      S_AW:   if (w_hs_aw) w_state_next = S_W;
      S_W:    if (w_hs_w && w_last_beat) w_state_next = S_B;
      S_B:    if (w_hs_b) w_state_next = w_last_burst ? S_AR : S_AW;
      S_AR:   if (w_hs_ar) w_state_next = S_R;
      S_R:    if (w_hs_r && w_last_beat) w_state_next = w_last_burst ? S_DONE : S_AR;
      S_DONE: w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
    if (w_timeout)
      w_state_next = S_DONE;
  end

  // State, beat/burst counters and the saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_burst   <= '0;
      r_beat    <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hs_w || w_hs_r)
        r_beat <= w_last_beat ? '0 : r_beat + KW'(1);
      if (w_burst_done)
        r_burst <= w_last_burst ? '0 : r_burst + BW'(1);
      r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_axi_req_gen.sv
// Bench for axi_req_gen: a memory slave with optional backpressure and fault injection,
// a scoreboard of expected AW/W/AR payloads, and directed end-of-sequence checks.
`timescale 1ns/1ps
module tb_axi_req_gen;
  localparam int NUM_REQ   = 8;
  localparam int BURST_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  m_awid, m_arid, m_bid, m_rid;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        req_finish, timeout_err;
  logic [15:0] err_cnt;

  int total = 0;
  int bad = 0;
  int aw_seen = 0;

  bit bp_en = 1'b0;
  bit aw_block = 1'b0;
  int corrupt_burst = -1, corrupt_beat = 0;
  int bresp_err_burst = -1;
  int rerr_burst = -1, rerr_beat = 0;

  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_ar_q[$];
  logic [32:0] exp_w_q[$];
  logic [31:0] mem [0:255];

  axi_req_gen #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .req_finish(req_finish), .err_cnt(err_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int stall();
    return bp_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  // Slave: snapshot DUT outputs at negedge, act on handshakes just after posedge
  initial begin : slave
    logic s_awv, s_wv, s_wl, s_br, s_arv, s_rr;
    logic [31:0] s_awa, s_wd, s_ara, wr_addr, rd_addr;
    int rd_k, wr_bursts, rd_bursts, aw_st, w_st, b_st, ar_st, r_st;
    bit rd_active, b_pending;
    m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
    m_bresp = 0; m_rresp = 0; m_rdata = 0; m_rlast = 0; m_bid = 0; m_rid = 0;
    wr_addr = 0; rd_addr = 0; rd_k = 0; wr_bursts = 0; rd_bursts = 0;
    aw_st = 0; w_st = 0; b_st = 0; ar_st = 0; r_st = 0; rd_active = 0; b_pending = 0;
    forever begin
      @(negedge clk);
      s_awv = m_awvalid; s_awa = m_awaddr; s_wv = m_wvalid; s_wd = m_wdata; s_wl = m_wlast;
      s_br = m_bready; s_arv = m_arvalid; s_ara = m_araddr; s_rr = m_rready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0; m_rlast = 0;
        rd_k = 0; wr_bursts = 0; rd_bursts = 0; rd_active = 0; b_pending = 0;
        aw_st = 0; w_st = 0; b_st = 0; ar_st = 0; r_st = 0;
        continue;
      end
      if (s_awv && m_awready) begin wr_addr = s_awa; aw_st = stall(); end
      if (s_wv && m_wready) begin
        mem[wr_addr[9:2]] = s_wd;
        wr_addr = wr_addr + 32'd4;
        w_st = stall();
        if (s_wl) begin b_pending = 1; b_st = stall(); end
      end
      if (m_bvalid && s_br) begin m_bvalid = 0; wr_bursts++; end
      if (s_arv && m_arready) begin
        rd_addr = s_ara; rd_k = 0; rd_active = 1; ar_st = stall(); r_st = stall();
      end
      if (m_rvalid && s_rr) begin
        m_rvalid = 0; m_rlast = 0; rd_addr = rd_addr + 32'd4; rd_k++; r_st = stall();
        if (rd_k == BURST_LEN) begin rd_active = 0; rd_bursts++; end
      end
      m_awready = !aw_block && (aw_st == 0); if (aw_st > 0) aw_st--;
      m_wready  = (w_st == 0);  if (w_st > 0) w_st--;
      m_arready = (ar_st == 0); if (ar_st > 0) ar_st--;
      if (b_pending && !m_bvalid) begin
        if (b_st == 0) begin
          m_bvalid = 1; b_pending = 0;
          m_bresp = (wr_bursts == bresp_err_burst) ? 2'b10 : 2'b00;
        end else b_st--;
      end
      if (rd_active && !m_rvalid) begin
        if (r_st == 0) begin
          m_rvalid = 1;
          m_rdata = mem[rd_addr[9:2]];
          if (rd_bursts == corrupt_burst && rd_k == corrupt_beat) m_rdata = m_rdata ^ 32'd1;
          m_rresp = (rd_bursts == rerr_burst && rd_k == rerr_beat) ? 2'b10 : 2'b00;
          m_rlast = (rd_k == BURST_LEN - 1) || (rd_bursts == rerr_burst && rd_k == rerr_beat);
        end else r_st--;
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks payload hold under stall
  initial begin : monitor
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_wl;
    logic [31:0] p_awa, p_wd, p_ara, e_a;
    logic [32:0] e_w;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_wl = 0;
    p_awa = 0; p_wd = 0; p_ara = 0;
    forever begin
      @(negedge clk);
      if (rst_n && !req_finish) begin
        if (p_awv && !p_awr) chk("aw_hold", {m_awvalid, m_awaddr}, {1'b1, p_awa});
        if (p_wv && !p_wr)   chk("w_hold", {m_wvalid, m_wlast, m_wdata}, {1'b1, p_wl, p_wd});
        if (p_arv && !p_arr) chk("ar_hold", {m_arvalid, m_araddr}, {1'b1, p_ara});
      end
      if (rst_n) begin
        if (m_awvalid && m_awready) begin
          aw_seen++;
          if (exp_aw_q.size() == 0) begin
            total++; bad++;
            $display("FAIL aw_extra: got addr 0x%0h expected no burst", m_awaddr);
          end else begin
            e_a = exp_aw_q.pop_front();
            chk("aw", {m_awid, m_awlen, m_awsize, m_awburst, m_awaddr},
                {4'h0, 8'h03, 3'h2, 2'h1, e_a});
            $display("AW  addr=0x%08h len=%0d", m_awaddr, m_awlen);
          end
        end
        if (m_wvalid && m_wready) begin
          if (exp_w_q.size() == 0) begin
            total++; bad++;
            $display("FAIL w_extra: got data 0x%0h expected no beat", m_wdata);
          end else begin
            e_w = exp_w_q.pop_front();
            chk("w", {m_wstrb, m_wlast, m_wdata}, {4'hF, e_w});
          end
        end
        if (m_arvalid && m_arready) begin
          if (exp_ar_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ar_extra: got addr 0x%0h expected no burst", m_araddr);
          end else begin
            e_a = exp_ar_q.pop_front();
            chk("ar", {m_arid, m_arlen, m_arsize, m_arburst, m_araddr},
                {4'h0, 8'h03, 3'h2, 2'h1, e_a});
            $display("AR  addr=0x%08h len=%0d", m_araddr, m_arlen);
          end
        end
        p_awv = m_awvalid; p_awr = m_awready; p_awa = m_awaddr;
        p_wv = m_wvalid; p_wr = m_wready; p_wd = m_wdata; p_wl = m_wlast;
        p_arv = m_arvalid; p_arr = m_arready; p_ara = m_araddr;
      end else begin
        p_awv = 0; p_wv = 0; p_arv = 0;
      end
    end
  end

  // Expected bursts: A(i) = i*16, beat k carries A(i)+4k, last flag on beat 3
  task automatic load_expected();
    logic [31:0] a;
    exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      a = 32'(i * 16);
      exp_aw_q.push_back(a);
      exp_ar_q.push_back(a);
      for (int k = 0; k < BURST_LEN; k++)
        exp_w_q.push_back({(k == BURST_LEN - 1), a + 32'(4 * k)});
    end
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_rst_valids"}, {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    chk({tag, "_rst_finish"}, req_finish, 0);
    chk({tag, "_rst_err"}, err_cnt, 0);
    chk({tag, "_rst_tmo"}, timeout_err, 0);
    load_expected();
    aw_seen = 0;
    #1 rst_n = 1;
  endtask

  task automatic wait_finish(input string tag, input int exp_err);
    int n;
    n = 0;
    while (!req_finish && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_finish"}, req_finish, 1);
    chk({tag, "_err_cnt"}, err_cnt, 64'(exp_err));
    chk({tag, "_tmo"}, timeout_err, 0);
    chk({tag, "_w_left"}, 64'(exp_w_q.size()), 0);
    chk({tag, "_ar_left"}, 64'(exp_ar_q.size()), 0);
    $display("%s  finish after %0d cycles err_cnt=%0d", tag, n, err_cnt);
  endtask

  initial begin : stim
    int n;
    // 1: zero-wait slave
    apply_reset("t1");
    wait_finish("t1", 0);
    chk("t1_mem4", mem[4], 32'h10);
    chk("t1_mem5", mem[5], 32'h14);
    chk("t1_mem6", mem[6], 32'h18);
    chk("t1_mem7", mem[7], 32'h1C);
    @(posedge clk); #3 rst_n = 0;
    #1 chk("t1_async_finish", req_finish, 0);
    // 2: random backpressure on every channel
    bp_en = 1;
    apply_reset("t2");
    wait_finish("t2", 0);
    bp_en = 0;
    // 3: one corrupted read beat
    corrupt_burst = 2; corrupt_beat = 1;
    apply_reset("t3");
    wait_finish("t3", 1);
    @(posedge clk); #3 rst_n = 0;
    #1 chk("t3_async_err", err_cnt, 0);
    corrupt_burst = -1;
    // 4: SLVERR write response plus SLVERR read beat with early rlast
    bresp_err_burst = 0; rerr_burst = 5; rerr_beat = 1;
    apply_reset("t4");
    wait_finish("t4", 3);
    bresp_err_burst = -1; rerr_burst = -1;
    // 5: reset during W of burst 3, then a clean rerun
    apply_reset("t5a");
    n = 0;
    while (!(aw_seen >= 4 && m_wvalid) && n < 2000) begin @(negedge clk); n++; end
    chk("t5_in_w", {m_wvalid, m_awaddr}, {1'b1, 32'h30});
    #2 rst_n = 0;
    #1 chk("t5_async_wvalid", m_wvalid, 0);
    chk("t5_async_finish", req_finish, 0);
    apply_reset("t5");
    wait_finish("t5", 0);
    // 6: awready stuck low
    aw_block = 1;
    apply_reset("t6");
    repeat (40) @(negedge clk);
`ifdef AXI_REQ_GEN_TIMEOUT_EN
    chk("t6_finish", req_finish, 1);
    chk("t6_tmo", timeout_err, 1);
    chk("t6_err", err_cnt, 1);
`else
    chk("t6_awvalid", m_awvalid, 1);
    chk("t6_awaddr", m_awaddr, 0);
    chk("t6_finish", req_finish, 0);
    chk("t6_tmo", timeout_err, 0);
`endif
    aw_block = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
